servant_gpio_bank: RTL and testbench

Parametrised GPIO peripheral for the servant SoC, replacing the single-bit, write-only GPIO slot on the servant_mux GPIO port with a 32-bit Wishbone register bank. It provides per-pin output, direction, synchronised input and edge-triggered interrupts. The interrupt is routed alongside the timer IRQ to the serv core. All pins are controlled through eight word registers decoded from the low address bits supplied by servant_mux.

---
 rtl/servant_gpio_bank.sv | 214 +++++++++++++++++++++
 tb/tb_servant_gpio_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_gpio_bank.sv
// servant_gpio_bank: 32-bit Wishbone GPIO bank with per-pin output, direction, synchronised input and edge IRQs.
// Define SERVANT_GPIO_IRQ_EN to build the IE/EDGE/PEND registers, edge detector and o_irq.
module servant_gpio_bank #(
    parameter int                  NUM_GPIO    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [NUM_GPIO-1:0] OUT_RESET   = {NUM_GPIO{1'b0}}
) (
    input  logic                i_wb_clk,
    input  logic                i_wb_rst_n,
    input  logic [2:0]          i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    input  logic [3:0]          i_wb_sel,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    output logic [31:0]         o_wb_rdt,
    output logic                o_wb_ack,
    input  logic [NUM_GPIO-1:0] i_gpio,
    output logic [NUM_GPIO-1:0] o_gpio,
    output logic [NUM_GPIO-1:0] o_gpio_oe,
    output logic                o_irq
);

    // Registers are held 32 bits wide; bits at and above NUM_GPIO are forced to zero on every write.
    localparam logic [31:0] GPIO_MASK = (NUM_GPIO >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << NUM_GPIO) - 32'd1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                req_s;
    logic                wr_s;
    logic                ack_r;
    logic [31:0]         rdt_r;
    logic [31:0]         rd_s;
    logic [31:0]         wmask_s;
    logic [31:0]         wdat_s;
    logic [31:0]         out_r;
    logic [31:0]         dir_r;
    logic [31:0]         in_s;
    logic [31:0]         ie_rd_s;
    logic [31:0]         edge_rd_s;
    logic [31:0]         pend_rd_s;
    logic [NUM_GPIO-1:0] sync_r [SYNC_STAGES];

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    assign wmask_s = byte_mask(i_wb_sel) & GPIO_MASK;
    assign wdat_s  = i_wb_dat & wmask_s;
    assign in_s    = 32'(sync_r[SYNC_STAGES-1]);

    // Bus FSM state register
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bus FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_wb_cyc) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus FSM outputs: a request is only taken in IDLE, so a cyc held through ACK cannot re-trigger
    always_comb begin
        req_s = 1'b0;
        case (state_r)
            ST_IDLE: req_s = i_wb_cyc;
            ST_ACK:  req_s = 1'b0;
            default: req_s = 1'b0;
        endcase
        wr_s = req_s & i_wb_we;
    end

    // Read data multiplexer
    always_comb begin
        rd_s = 32'd0;
        case (i_wb_adr)
            3'd0:    rd_s = out_r;
            3'd1:    rd_s = dir_r;
            3'd2:    rd_s = in_s;
            3'd3:    rd_s = ie_rd_s;
            3'd4:    rd_s = edge_rd_s;
            3'd5:    rd_s = pend_rd_s;
            default: rd_s = 32'd0;
        endcase
    end

    // Registered acknowledge and read data
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            ack_r <= 1'b0;
            rdt_r <= 32'd0;
        end else begin
            ack_r <= req_s;
            if (req_s) begin
                rdt_r <= rd_s;
            end else begin
                rdt_r <= rdt_r;
            end
        end
    end

    // OUT and DIR registers, including the SET/CLR aliases of OUT
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            out_r <= 32'(OUT_RESET);
            dir_r <= 32'd0;
        end else if (wr_s) begin
            case (i_wb_adr)
                3'd0:    out_r <= (out_r & ~wmask_s) | wdat_s;
                3'd1:    dir_r <= (dir_r & ~wmask_s) | wdat_s;
                3'd6:    out_r <= out_r | wdat_s;
                3'd7:    out_r <= out_r & ~wdat_s;
                default: out_r <= out_r;
            endcase
        end else begin
            out_r <= out_r;
        end
    end

    // Input synchroniser chain
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {NUM_GPIO{1'b0}};
            end
        end else begin
            sync_r[0] <= i_gpio;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

`ifdef SERVANT_GPIO_IRQ_EN
    logic [31:0] ie_r;
    logic [31:0] edge_r;
    logic [31:0] pend_r;
    logic [31:0] prev_r;
    logic [31:0] event_s;
    logic [31:0] w1c_s;
    logic        irq_r;

    assign event_s = ie_r & ((edge_r & in_s & ~prev_r) | (~edge_r & ~in_s & prev_r));

    // Write-1-to-clear mask for PEND
    always_comb begin
        if (wr_s && (i_wb_adr == 3'd5)) begin
            w1c_s = wdat_s;
        end else begin
            w1c_s = 32'd0;
        end
    end

    // Interrupt registers; an edge in the same cycle as a W1C keeps the bit set
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            ie_r   <= 32'd0;
            edge_r <= 32'd0;
            pend_r <= 32'd0;
            prev_r <= 32'd0;
            irq_r  <= 1'b0;
        end else begin
            if (wr_s) begin
                case (i_wb_adr)
                    3'd3:    ie_r   <= (ie_r & ~wmask_s) | wdat_s;
                    3'd4:    edge_r <= (edge_r & ~wmask_s) | wdat_s;
                    default: ie_r   <= ie_r;
                endcase
            end else begin
                ie_r <= ie_r;
            end
            prev_r <= in_s;
            pend_r <= (pend_r & ~w1c_s) | event_s;
            irq_r  <= |(pend_r & ie_r);
        end
    end

    assign ie_rd_s   = ie_r;
    assign edge_rd_s = edge_r;
    assign pend_rd_s = pend_r;
    assign o_irq     = irq_r;
`else
    assign ie_rd_s   = 32'd0;
    assign edge_rd_s = 32'd0;
    assign pend_rd_s = 32'd0;
    assign o_irq     = 1'b0;
`endif

    assign o_wb_ack  = ack_r;
    assign o_wb_rdt  = rdt_r;
    assign o_gpio    = out_r[NUM_GPIO-1:0];
    assign o_gpio_oe = dir_r[NUM_GPIO-1:0];

endmodule

// File: tb/tb_servant_gpio_bank.sv
// Randomised self-checking bench for servant_gpio_bank against a cycle-level behavioural model.
// Expectations follow SERVANT_GPIO_IRQ_EN, so the bench suits either build.
module tb_servant_gpio_bank;

    localparam int          N  = 8;
    localparam int          S  = 2;
    localparam logic [N-1:0] OR = 8'h3C;
    localparam logic [31:0] GM = 32'h0000_00FF;
`ifdef SERVANT_GPIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   adr = 3'd0;
    logic [31:0]  dat = 32'd0;
    logic [3:0]   sel = 4'd0;
    logic         we = 1'b0;
    logic         cyc = 1'b0;
    logic [31:0]  rdt;
    logic         ack;
    logic [N-1:0] gpio_in = {N{1'b0}};
    logic [N-1:0] gpio_out;
    logic [N-1:0] gpio_oe;
    logic         irq;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers plus the history of sampled pin values
    logic [31:0] m_out, m_dir, m_ie, m_edge, m_pend, m_rdt;
    logic        m_irq, m_ack;
    logic [31:0] hist [S+1];

    servant_gpio_bank #(.NUM_GPIO(N), .SYNC_STAGES(S), .OUT_RESET(OR)) dut (
        .i_wb_clk  (clk),
        .i_wb_rst_n(rst_n),
        .i_wb_adr  (adr),
        .i_wb_dat  (dat),
        .i_wb_sel  (sel),
        .i_wb_we   (we),
        .i_wb_cyc  (cyc),
        .o_wb_rdt  (rdt),
        .o_wb_ack  (ack),
        .i_gpio    (gpio_in),
        .o_gpio    (gpio_out),
        .o_gpio_oe (gpio_oe),
        .o_irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        m = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) m = m | (32'h0000_00FF << (8 * b));
        end
        return m;
    endfunction

    task automatic model_reset();
        m_out  = 32'(OR);
        m_dir  = 32'd0;
        m_ie   = 32'd0;
        m_edge = 32'd0;
        m_pend = 32'd0;
        m_rdt  = 32'd0;
        m_irq  = 1'b0;
        m_ack  = 1'b0;
        for (int k = 0; k <= S; k++) hist[k] = 32'd0;
    endtask

    // One clock edge of the reference: IN is the pin value sampled S edges ago
    task automatic model_edge();
        logic [31:0] in_b, prev_b, ev, wm, wd, w1c;
        logic        acc, nirq;
        in_b   = hist[S-1];
        prev_b = hist[S];
        acc    = cyc && !m_ack;
        nirq   = |(m_pend & m_ie);
        ev     = 32'd0;
        if (IRQ_EN) ev = m_ie & ((m_edge & in_b & ~prev_b) | (~m_edge & ~in_b & prev_b));
        if (acc) begin
            case (adr)
                3'd0:    m_rdt = m_out;
                3'd1:    m_rdt = m_dir;
                3'd2:    m_rdt = in_b;
                3'd3:    m_rdt = m_ie;
                3'd4:    m_rdt = m_edge;
                3'd5:    m_rdt = m_pend;
                default: m_rdt = 32'd0;
            endcase
        end
        wm  = lanes(sel) & GM;
        wd  = dat & wm;
        w1c = 32'd0;
        if (acc && we) begin
            case (adr)
                3'd0: m_out = (m_out & ~wm) | wd;
                3'd1: m_dir = (m_dir & ~wm) | wd;
                3'd3: if (IRQ_EN) m_ie = (m_ie & ~wm) | wd;
                3'd4: if (IRQ_EN) m_edge = (m_edge & ~wm) | wd;
                3'd5: w1c = wd;
                3'd6: m_out = m_out | wd;
                3'd7: m_out = m_out & ~wd;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~w1c) | ev;
        m_irq  = nirq;
        m_ack  = acc;
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = 32'(gpio_in);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ack", 32'(ack), 32'(m_ack));
        chk("gpio", 32'(gpio_out), m_out & GM);
        chk("oe", 32'(gpio_oe), m_dir & GM);
        chk("irq", 32'(irq), 32'(m_irq));
        if (m_ack) chk("rdt", rdt, m_rdt);
    endtask

    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got;
        got = 1'b0;
        cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        for (int k = 0; k < 4 && !got; k++) begin
            tick();
            if (ack) got = 1'b1;
        end
        if (!got) chk("bus_timeout", 32'd0, 32'd1);
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_oe", 32'(gpio_oe), 32'd0);
        chk("rst_gpio", 32'(gpio_out), 32'(OR));
        for (int a = 0; a < 8; a++) begin
            bus(1'b0, 3'(a), 32'd0, 4'hF);
            chk("rst_reg", rdt, (a == 0) ? 32'(OR) : 32'd0);
        end

        // OUT with byte lanes, then SET and CLR aliases
        bus(1'b1, 3'd0, 32'h0000_00A5, 4'b0001);
        bus(1'b1, 3'd6, 32'h0000_000A, 4'hF);
        bus(1'b1, 3'd7, 32'h0000_0001, 4'hF);
        bus(1'b0, 3'd0, 32'd0, 4'hF);
        chk("out_rd", rdt, 32'h0000_00AE);
        chk("out_pin", 32'(gpio_out), 32'h0000_00AE);
        bus(1'b0, 3'd6, 32'd0, 4'hF);
        chk("set_rd0", rdt, 32'd0);

        // DIR byte lanes
        bus(1'b1, 3'd1, 32'h0000_00FF, 4'b0010);
        bus(1'b0, 3'd1, 32'd0, 4'hF);
        chk("dir_lane", rdt, 32'd0);
        bus(1'b1, 3'd1, 32'h0000_000F, 4'b0001);
        chk("dir_oe", 32'(gpio_oe), 32'h0000_000F);

        // Rising edge on pin 0: PEND one edge after IN, IRQ one edge after PEND
        bus(1'b1, 3'd3, 32'h0000_0001, 4'hF);
        bus(1'b1, 3'd4, 32'h0000_0001, 4'hF);
        ticks(2);
        gpio_in[0] = 1'b1;
        ticks(3);
        chk("irq_early", 32'(irq), 32'd0);
        tick();
        chk("irq_lat", 32'(irq), 32'(IRQ_EN));
        bus(1'b0, 3'd5, 32'd0, 4'hF);
        chk("pend_rd", rdt, IRQ_EN ? 32'd1 : 32'd0);
        bus(1'b1, 3'd5, 32'h0000_0001, 4'hF);
        tick();
        chk("irq_w1c", 32'(irq), 32'd0);

        // Falling edge on disabled pin 3 is discarded
        gpio_in[3] = 1'b1;
        ticks(4);
        gpio_in[3] = 1'b0;
        ticks(4);
        bus(1'b1, 3'd3, 32'h0000_0009, 4'hF);
        ticks(4);
        bus(1'b0, 3'd5, 32'd0, 4'hF);
        chk("pend_dis", rdt, 32'd0);
        chk("irq_dis", 32'(irq), 32'd0);

        // Edge on pin 0 coincides with W1C of PEND[0]: set wins
        gpio_in[0] = 1'b0;
        ticks(4);
        gpio_in[0] = 1'b1;
        ticks(2);
        bus(1'b1, 3'd5, 32'h0000_0001, 4'hF);
        bus(1'b0, 3'd5, 32'd0, 4'hF);
        chk("pend_race", rdt, IRQ_EN ? 32'd1 : 32'd0);
        chk("irq_race", 32'(irq), 32'(IRQ_EN));

        // Random traffic with back-to-back requests and toggling pins
        for (int i = 0; i < 1500; i++) begin
            if (cyc && ack) begin
                cyc = 1'b0;
                if ($urandom_range(3) == 0) cyc = 1'b1;
            end else if (!cyc && $urandom_range(2) == 0) begin
                cyc = 1'b1;
            end
            if (cyc && !ack) begin
                we  = 1'($urandom_range(1));
                adr = 3'($urandom_range(7));
                dat = $urandom;
                sel = 4'($urandom_range(15));
            end
            if ($urandom_range(3) == 0) gpio_in = N'($urandom);
            tick();
        end
        cyc = 1'b0;
        ticks(2);

        // Reset during ACK: ack falls at once and registers return to reset values
        bus(1'b1, 3'd1, 32'h0000_00F0, 4'hF);
        cyc = 1'b1; we = 1'b1; adr = 3'd0; dat = 32'h0000_00FF; sel = 4'hF;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_out", 32'(gpio_out), 32'(OR));
        chk("rst_dir", 32'(gpio_oe), 32'd0);
        chk("rst_irq2", 32'(irq), 32'd0);
        model_reset();
        cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus(1'b0, 3'd0, 32'd0, 4'hF);
        chk("rst_out_rd", rdt, 32'(OR));
        bus(1'b0, 3'd5, 32'd0, 4'hF);
        chk("rst_pend_rd", rdt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
